// File: rtl/rpu_pkg.sv
// Shared types for the RPU spike path: routed spike event layout,
// axon receiver dispatch states and the neuron id width.
package rpu_pkg;

    localparam int NEURON_ID_W = 4;

    typedef struct packed {
        logic [NEURON_ID_W-1:0] source_id;
        logic [NEURON_ID_W-1:0] target_id;
    } spike_event_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        GAP     = 2'd2
    } rx_state_t;

    function automatic spike_event_t make_event(
        input logic [NEURON_ID_W-1:0] src,
        input logic [NEURON_ID_W-1:0] tgt
    );
        spike_event_t ev;
        ev.source_id = src;
        ev.target_id = tgt;
        return ev;
    endfunction

endpackage

// File: rtl/axon_receiver_if.sv
// Valid/ready spike-event link between the axon routing fabric (master)
// and the axon receiver (slave).
interface axon_receiver_if;
    import rpu_pkg::*;

    logic                   spike_valid;
    logic [NEURON_ID_W-1:0] source_id;
    logic [NEURON_ID_W-1:0] target_id;
    logic                   spike_ready;

    modport master (
        output spike_valid,
        output source_id,
        output target_id,
        input  spike_ready
    );

    modport slave (
        input  spike_valid,
        input  source_id,
        input  target_id,
        output spike_ready
    );

endinterface

// File: rtl/spike_event_fifo.sv
// Synchronous first-word-fall-through event buffer with registered
// full/empty flags; clr empties it in one edge.
module spike_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic              do_push_s;
    logic              do_pop_s;
    logic [PTR_W:0]    count_nxt_s;

    assign do_push_s = push & ~full & ~clr;
    assign do_pop_s  = pop & ~empty & ~clr;
    assign dout      = mem_r[rd_ptr_r];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count;
        if (do_push_s && !do_pop_s) begin
            count_nxt_s = count + CNT_ONE;
        end else if (!do_push_s && do_pop_s) begin
            count_nxt_s = count - CNT_ONE;
        end else begin
            count_nxt_s = count;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count <= count_nxt_s;
            full  <= (count_nxt_s == CNT_FULL);
            empty <= (count_nxt_s == '0);
        end
    end

endmodule

// File: rtl/axon_receiver.sv
// Axon receiver: buffers routed spike events and dispatches them as one-hot
// neuron pulses with a minimum gap. Define AXON_RX_STATS_EN for counters.
module axon_receiver
    import rpu_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int MIN_GAP     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    axon_receiver_if.slave                rx,
    input  logic                          deliver_en,
    input  logic                          flush,
    output logic [NUM_NEURONS-1:0]        neuron_spike,
    output logic [NEURON_ID_W-1:0]        spike_src,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
`ifdef AXON_RX_STATS_EN
    ,
    output logic [15:0]                   deliver_count,
    output logic [7:0]                    drop_count
`endif
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [NEURON_ID_W:0] NEURON_LIM = NUM_NEURONS[NEURON_ID_W:0];

    spike_event_t       in_ev_s;
    spike_event_t       head_ev_s;
    logic [7:0]         fifo_dout_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               accept_s;
    logic               in_range_s;
    logic               push_s;
    logic               pop_s;
    rx_state_t          state_r;
    logic [GAP_W-1:0]   gap_cnt_r;

    // Ready follows the registered full flag, but a flush cycle must refuse
    // the beat in the same cycle so nothing is taken and then thrown away.
    assign rx.spike_ready = ~fifo_full_s & ~flush;
    assign accept_s       = rx.spike_valid & rx.spike_ready;
    assign in_range_s     = ({1'b0, rx.target_id} < NEURON_LIM);
    assign push_s         = accept_s & in_range_s;
    assign pop_s          = (state_r == IDLE) & ~fifo_empty_s & deliver_en & ~flush;
    assign in_ev_s        = make_event(rx.source_id, rx.target_id);
    assign head_ev_s      = fifo_dout_s;
    assign busy           = ~fifo_empty_s | (state_r != IDLE);

    spike_event_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push_s),
        .din   (in_ev_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .count (fifo_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Dispatch FSM: one-cycle pulse, then MIN_GAP idle cycles, then IDLE again.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r      <= IDLE;
            neuron_spike <= '0;
            spike_src    <= '0;
            gap_cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        state_r      <= DELIVER;
                        neuron_spike <= NUM_NEURONS'(1'b1) << head_ev_s.target_id;
                        spike_src    <= head_ev_s.source_id;
                    end
                end
                DELIVER: begin
                    neuron_spike <= '0;
                    spike_src    <= '0;
                    gap_cnt_r    <= '0;
                    state_r      <= (MIN_GAP > 0) ? GAP : IDLE;
                end
                GAP: begin
                    if (gap_cnt_r == GAP_W'(MIN_GAP - 1)) begin
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    neuron_spike <= '0;
                    spike_src    <= '0;
                    gap_cnt_r    <= '0;
                end
            endcase
        end
    end

`ifdef AXON_RX_STATS_EN
    // Saturating statistics; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            deliver_count <= 16'd0;
            drop_count    <= 8'd0;
        end else begin
            if (pop_s && (deliver_count != 16'hFFFF)) begin
                deliver_count <= deliver_count + 16'd1;
            end
            if (accept_s && !in_range_s && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axon_receiver.sv
// Self-checking bench for axon_receiver: directed scenarios plus random
// traffic, checked every cycle against a queue-based behavioural model.
module tb_axon_receiver;
    import rpu_pkg::*;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int G  = 2;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          deliver_en = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  neuron_spike;
    logic [3:0]    spike_src;
    logic [CW-1:0] fifo_count;
    logic          busy;
`ifdef AXON_RX_STATS_EN
    logic [15:0]   deliver_count;
    logic [7:0]    drop_count;
`endif

    axon_receiver_if bus ();

    axon_receiver #(
        .NUM_NEURONS (N),
        .FIFO_DEPTH  (D),
        .MIN_GAP     (G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (bus),
        .deliver_en   (deliver_en),
        .flush        (flush),
        .neuron_spike (neuron_spike),
        .spike_src    (spike_src),
        .fifo_count   (fifo_count),
        .busy         (busy)
`ifdef AXON_RX_STATS_EN
        ,
        .deliver_count (deliver_count),
        .drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int since = G + 1;      // edges since the last pulse, saturating at G+1 (= idle)
    int exp_deliv = 0;
    int exp_drop = 0;
    spike_event_t pend[$];  // in-range events accepted but not yet pulsed
    spike_event_t tx[$];    // sender's outstanding beats
    int pulse_t[$];

    function automatic spike_event_t mk(input int s, input int t);
        return make_event(4'(s), 4'(t));
    endfunction

    task automatic step(input logic r, input logic f, input logic en, input logic offer);
        logic         rdy_exp;
        logic         acc_exp;
        logic         pulse_exp;
        logic         busy_exp;
        spike_event_t head;
        spike_event_t dummy;
        logic [N-1:0] exp_ns;
        logic [3:0]   exp_src;
        rst = r;
        flush = f;
        deliver_en = en;
        bus.spike_valid = offer && (tx.size() > 0);
        if (tx.size() > 0) begin
            bus.source_id = tx[0].source_id;
            bus.target_id = tx[0].target_id;
        end else begin
            bus.source_id = 4'($urandom);
            bus.target_id = 4'($urandom);
        end
        #1;
        rdy_exp = (pend.size() < D) && !f;
        if (!r) begin
            total++;
            assert (bus.spike_ready === rdy_exp)
                else begin bad++; $error("FAIL ready cyc=%0d obs=%b exp=%b", cyc, bus.spike_ready, rdy_exp); end
        end
        acc_exp = bus.spike_valid && rdy_exp && !r;
        if (bus.spike_valid && bus.spike_ready && !r) dummy = tx.pop_front();
        @(posedge clk);
        #1;
        cyc++;
        exp_ns = '0;
        exp_src = 4'd0;
        if (r) begin
            pend.delete();
            since = G + 1;
            exp_deliv = 0;
            exp_drop = 0;
        end else if (f) begin
            pend.delete();
            since = G + 1;
        end else begin
            pulse_exp = en && (since >= G + 1) && (pend.size() > 0);
            if (pulse_exp) begin
                head = pend.pop_front();
                exp_ns = N'(1) << head.target_id;
                exp_src = head.source_id;
                since = 0;
                if (exp_deliv < 65535) exp_deliv++;
                pulse_t.push_back(cyc);
            end else if (since < G + 1) begin
                since++;
            end
            if (acc_exp) begin
                if (int'(bus.target_id) < N) pend.push_back(make_event(bus.source_id, bus.target_id));
                else if (exp_drop < 255) exp_drop++;
            end
        end
        busy_exp = (pend.size() != 0) || (since < G + 1);
        total++;
        assert (neuron_spike === exp_ns)
            else begin bad++; $error("FAIL spike cyc=%0d obs=%h exp=%h", cyc, neuron_spike, exp_ns); end
        total++;
        assert (spike_src === exp_src)
            else begin bad++; $error("FAIL src cyc=%0d obs=%h exp=%h", cyc, spike_src, exp_src); end
        total++;
        assert (fifo_count === CW'(pend.size()))
            else begin bad++; $error("FAIL count cyc=%0d obs=%0d exp=%0d", cyc, fifo_count, pend.size()); end
        total++;
        assert (busy === busy_exp)
            else begin bad++; $error("FAIL busy cyc=%0d obs=%b exp=%b", cyc, busy, busy_exp); end
`ifdef AXON_RX_STATS_EN
        total++;
        assert (deliver_count === 16'(exp_deliv))
            else begin bad++; $error("FAIL deliver_count cyc=%0d obs=%0d exp=%0d", cyc, deliver_count, exp_deliv); end
        total++;
        assert (drop_count === 8'(exp_drop))
            else begin bad++; $error("FAIL drop_count cyc=%0d obs=%0d exp=%0d", cyc, drop_count, exp_drop); end
`endif
    endtask

    initial begin
        int base;
        bus.spike_valid = 1'b0;
        bus.source_id = 4'd0;
        bus.target_id = 4'd0;

        // Reset.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        assert (bus.spike_ready === 1'b1 && neuron_spike === '0 && busy === 1'b0)
            else begin bad++; $error("FAIL reset_state rdy=%b spike=%h busy=%b exp 1/0/0", bus.spike_ready, neuron_spike, busy); end

        // Out-of-range target (15 >= 8): consumed, never pulsed.
        tx.push_back(mk(7, 15));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        assert (pulse_t.size() == 0 && tx.size() == 0)
            else begin bad++; $error("FAIL drop_no_pulse pulses=%0d tx=%0d exp 0/0", pulse_t.size(), tx.size()); end
`ifdef AXON_RX_STATS_EN
        total++;
        assert (drop_count === 8'd1 && deliver_count === 16'd0)
            else begin bad++; $error("FAIL drop_stats drop=%0d deliv=%0d exp 1/0", drop_count, deliver_count); end
`endif

        // Single beat src=3 tgt=5: pulse on the edge after acceptance.
        tx.push_back(mk(3, 5));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        assert (neuron_spike === 8'h20 && spike_src === 4'd3)
            else begin bad++; $error("FAIL single_beat spike=%h src=%0d exp 20/3", neuron_spike, spike_src); end
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Back-pressure: 5 beats with dispatch held, 4 fit, 5th waits.
        for (int i = 0; i < 5; i++) tx.push_back(mk(i + 1, (i * 3) % N));
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        assert (tx.size() == 1 && fifo_count === CW'(D))
            else begin bad++; $error("FAIL backpressure tx=%0d count=%0d exp 1/%0d", tx.size(), fifo_count, D); end
        base = pulse_t.size();
        repeat (30) step(1'b0, 1'b0, 1'b1, 1'b1);
        total++;
        assert (pulse_t.size() == base + 5)
            else begin bad++; $error("FAIL burst_pulses obs=%0d exp=5", pulse_t.size() - base); end
        for (int i = 1; i < 5 && base + i < pulse_t.size(); i++) begin
            total++;
            assert (pulse_t[base + i] - pulse_t[base + i - 1] == G + 2)
                else begin bad++; $error("FAIL burst_spacing obs=%0d exp=%0d", pulse_t[base + i] - pulse_t[base + i - 1], G + 2); end
        end

        // Flush with three queued and one pulse in flight; offered beat is refused.
        for (int i = 0; i < 4; i++) tx.push_back(mk(8 + i, i + 2));
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tx.push_back(mk(9, 1));
        step(1'b0, 1'b1, 1'b1, 1'b1);
        total++;
        assert (neuron_spike === '0 && fifo_count === '0 && tx.size() == 1)
            else begin bad++; $error("FAIL flush spike=%h count=%0d tx=%0d exp 0/0/1", neuron_spike, fifo_count, tx.size()); end
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b1);

        // Steady one beat every 4 cycles: occupancy alternates 1/0.
        for (int i = 0; i < 6; i++) begin
            tx.push_back(mk(i, 7 - i));
            step(1'b0, 1'b0, 1'b1, 1'b1);
            repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Reset in the middle of GAP with two events still queued.
        for (int i = 0; i < 3; i++) tx.push_back(mk(12, i + 4));
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        assert (neuron_spike === '0 && spike_src === 4'd0 && fifo_count === '0 && busy === 1'b0)
            else begin bad++; $error("FAIL mid_gap_reset spike=%h src=%0d count=%0d busy=%b", neuron_spike, spike_src, fifo_count, busy); end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional flushes and dispatch stalls.
        for (int i = 0; i < 400; i++) begin
            if (tx.size() < 2 && $urandom_range(2) == 0)
                tx.push_back(mk($urandom_range(15), $urandom_range(15)));
            step(1'b0, ($urandom_range(39) == 0), ($urandom_range(3) != 0), ($urandom_range(3) != 0));
        end
        repeat (40) step(1'b0, 1'b0, 1'b1, 1'b1);
        total++;
        assert (tx.size() == 0 && pend.size() == 0 && busy === 1'b0)
            else begin bad++; $error("FAIL drain tx=%0d pend=%0d busy=%b exp 0/0/0", tx.size(), pend.size(), busy); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axon_receiver.md
Name: axon_receiver

Overview:
Receiving end of the axon spike-routing link. Accepts routed spike events (source_id, target_id) from an upstream axon interface over a valid/ready handshake and buffers them in a small FIFO. Dispatches each event as a one-cycle, one-hot spike pulse on the addressed neuron's input line, with a programmable minimum inter-spike gap. Sits between the axon routing fabric and the neuron_core array; rpu_controller drives its flush and enable inputs.

Parameters:
NUM_NEURONS, 16, number of target neuron lines; legal target_id range 0..NUM_NEURONS-1 (max 16)
FIFO_DEPTH, 4, event buffer entries; power of two, >= 2
MIN_GAP, 2, idle cycles forced between consecutive delivered pulses; 0 allowed

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
spike_valid  input  1  upstream event valid
source_id  input  4  originating neuron id
target_id  input  4  destination neuron id
spike_ready  output  1  receiver can accept; registered
deliver_en  input  1  controller permits dispatch; 0 = hold events in FIFO
flush  input  1  synchronous clear of FIFO and FSM (driven by reset_neurons)
neuron_spike  output  NUM_NEURONS  one-hot spike pulse to neuron array
spike_src  output  4  source_id of the event on neuron_spike; 0 when no pulse
fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst=1 at edge): FIFO empty, pointers 0, FSM=IDLE, neuron_spike=0, spike_src=0, fifo_count=0, busy=0, spike_ready=1 from the first cycle after reset.
- Handshake: a beat transfers at an edge where spike_valid & spike_ready. spike_ready = (fifo_count < FIFO_DEPTH) & !flush. While ready=0, the sender holds its beat; no event is ever silently lost on a full FIFO.
- Target check: an accepted beat with target_id >= NUM_NEURONS is consumed, not written, and not delivered.
- FSM states: IDLE, DELIVER, GAP.
  - IDLE -> DELIVER when FIFO non-empty and deliver_en=1. At that edge, pop the head and register neuron_spike = 1<<target, spike_src = source.
  - DELIVER lasts one cycle. At the next edge neuron_spike and spike_src clear. Go to GAP if MIN_GAP>0, else IDLE.
  - GAP counts MIN_GAP cycles, then goes to IDLE.
  - Minimum pulse spacing is MIN_GAP+2 edges. At MIN_GAP=0 it is 2 edges, because IDLE is always revisited.
- Latency: beat accepted at edge k into an empty FIFO with FSM in IDLE -> neuron_spike high from edge k+1 to edge k+2.
- Push and pop at the same edge are legal at any occupancy below full; fifo_count stays unchanged.
- deliver_en=0: no pop from IDLE. A DELIVER or GAP already in progress completes normally.
- flush (priority below rst, above everything else): FIFO emptied, FSM=IDLE, neuron_spike=0, spike_src=0 at that edge. Any beat offered in a flush cycle is not accepted, because ready=0.
- Pointers wrap modulo FIFO_DEPTH. Occupancy never exceeds FIFO_DEPTH.
- At most one bit of neuron_spike is set in any cycle.

Optional Feature:
AXON_RX_STATS_EN
- Defined: adds outputs deliver_count[15:0] (increments on every pulse) and drop_count[7:0] (increments on every out-of-range target accepted). Both counters saturate at all-ones, clear on rst, and are unaffected by flush.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package rpu_pkg holds:
  - the spike-event typedef (4-bit source_id, 4-bit target_id);
  - the FSM state encoding (IDLE=2'd0, DELIVER=2'd1, GAP=2'd2);
  - the NEURON_ID_W=4 constant.
- One sub-module is natural: spike_event_fifo (synchronous, parameterised depth, 8-bit data, push/pop/count/full/empty). The dispatch FSM and target check stay in axon_receiver.

Test Plan:
- Reset, then a single beat src=3, tgt=5 at edge k -> neuron_spike=16'h0020, spike_src=3 during edge k+1..k+2; fifo_count returns to 0; busy drops after the GAP.
- deliver_en=0, push 5 beats, FIFO_DEPTH=4 -> 4 accepted, spike_ready=0 on the 5th and the sender holds it. Raise deliver_en -> all 5 delivered in order, spaced exactly 4 edges apart (MIN_GAP=2).
- Beat with tgt=15 at NUM_NEURONS=8 -> no pulse. With AXON_RX_STATS_EN, drop_count becomes 1 and deliver_count stays 0.
- Flush with 3 events queued and a pulse in flight -> neuron_spike=0 and fifo_count=0 after the flush edge; a beat offered in the flush cycle is not accepted.
- Simultaneous push/pop: steady one beat every 4 cycles -> fifo_count alternates 1/0 and never exceeds 1; every target pulses once.
- rst asserted mid-GAP with 2 events queued -> all outputs at reset values next cycle; spike_ready=1.
